program_counter_stack: RTL

- Parametrised successor to the 4-bit program counter in the bus-based CPU datapath.
- Holds the current instruction address and drives it onto the shared bus through a tri-state output.
- Adds configurable width, a hardware call/return stack, a halt freeze and error/status flags.
- Sits between the control sequencer (increment, jump, call and return strobes) and the shared bus (jump targets in, address out to the memory address register).

---
 rtl/program_counter_stack.sv | 118 +++++++++++
 1 files changed

// File: rtl/program_counter_stack.sv
// Program counter with tri-state bus driver, hardware call/return stack and halt freeze.
// Optional macro PC_WRAP_HALT_EN: an increment at all-ones freezes the PC and sets halted.
module program_counter_stack #(
    parameter int                ADDR_W      = 4,
    parameter int                STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_ADDR  = '0
) (
    input  logic              clock,
    input  logic              clear_n,
    input  logic              pc_inc,
    input  logic              jmp,
    input  logic              call,
    input  logic              ret,
    input  logic              halt,
    input  logic              pc_out,
    input  logic [ADDR_W-1:0] bus_in,
    output logic [ADDR_W-1:0] bus_out,
    output logic [ADDR_W-1:0] pc_value,
    output logic              stack_full,
    output logic              stack_empty,
    output logic              stack_err,
    output logic              halted
);
    // The pointer must reach STACK_DEPTH itself, so it is one count wider than the index.
    localparam int PTR_W = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_FULL = PTR_W'(STACK_DEPTH);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d, ptr_dec;
    logic              err_q, err_d;
    logic              push;
    logic              frozen;
    logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];

`ifdef PC_WRAP_HALT_EN
    logic halted_q, halted_d;
    assign frozen = halt | halted_q;
    assign halted = halted_q;
`else
    assign frozen = halt;
    assign halted = 1'b0;
`endif

    assign ptr_dec     = ptr_q - PTR_W'(1);
    assign stack_full  = (ptr_q == PTR_FULL);
    assign stack_empty = (ptr_q == '0);
    assign stack_err   = err_q;
    assign pc_value    = pc_q;
    assign bus_out     = pc_out ? pc_q : {ADDR_W{1'bz}};

    // Priority: halt > ret > call > jmp > pc_inc; exactly one action per edge.
    always_comb begin
        pc_d  = pc_q;
        ptr_d = ptr_q;
        err_d = err_q;
        push  = 1'b0;
`ifdef PC_WRAP_HALT_EN
        halted_d = halted_q;
`endif
        if (frozen) begin
            pc_d = pc_q;
        end else if (ret) begin
            if (stack_empty) begin
                err_d = 1'b1;
            end else begin
                ptr_d = ptr_dec;
                pc_d  = stack_mem[IDX_W'(ptr_dec)];
            end
        end else if (call) begin
            if (stack_full) begin
                err_d = 1'b1;
            end else begin
                push  = 1'b1;
                ptr_d = ptr_q + PTR_W'(1);
                pc_d  = bus_in;
            end
        end else if (jmp) begin
            pc_d = bus_in;
        end else if (pc_inc) begin
`ifdef PC_WRAP_HALT_EN
            if (&pc_q) begin
                halted_d = 1'b1;
            end else begin
                pc_d = pc_q + ADDR_W'(1);
            end
`else
            pc_d = pc_q + ADDR_W'(1);
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (!clear_n) begin
            pc_q  <= RESET_ADDR;
            ptr_q <= '0;
            err_q <= 1'b0;
`ifdef PC_WRAP_HALT_EN
            halted_q <= 1'b0;
`endif
        end else begin
            pc_q  <= pc_d;
            ptr_q <= ptr_d;
            err_q <= err_d;
`ifdef PC_WRAP_HALT_EN
            halted_q <= halted_d;
`endif
        end
    end

    // Return addresses are not reset; a push is suppressed while reset is asserted.
    always_ff @(posedge clock) begin
        if (push && clear_n) begin
            stack_mem[IDX_W'(ptr_q)] <= pc_q;
        end
    end

endmodule
